// File: rtl/conv_seq_pkg.sv
// Shared encodings for the convolution sequencer: FSM states and the default address width.
package conv_seq_pkg;

    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/conv_index_bounds.sv
// Combinational k range for output i: k_lo = max(0, i-M+1), k_hi = min(i, N-1).
// Both bounds are < N <= 2**ADDR_W, so they are returned as ADDR_W-bit addresses.
module conv_index_bounds
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W:0]   i_idx,
    input  logic [ADDR_W:0]   i_size_x,
    input  logic [ADDR_W:0]   i_size_y,
    output logic [ADDR_W-1:0] o_k_lo,
    output logic [ADDR_W-1:0] o_k_hi
);

    localparam logic [ADDR_W:0]   W_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    // Range tests use full width; the results fit ADDR_W bits, so the
    // subtraction is done modulo 2**ADDR_W without losing information.
    always_comb begin
        o_k_lo = '0;
        if (i_idx >= i_size_y)
            o_k_lo = i_idx[ADDR_W-1:0] - i_size_y[ADDR_W-1:0] + A_ONE;
        if (i_idx < i_size_x - W_ONE)
            o_k_hi = i_idx[ADDR_W-1:0];
        else
            o_k_hi = i_size_x[ADDR_W-1:0] - A_ONE;
    end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution sequencer: walks X/Y memories and drives MAC/Z-write for Z[i]=sum x[k]*y[i-k].
// Optional busy-cycle counter built when CONV_CYCLE_CNT_EN is defined; otherwise cycle_cnt is 0.
module conv_sequencer
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              en_s,
    input  logic              start,
    input  logic [ADDR_W:0]   size_x,
    input  logic [ADDR_W:0]   size_y,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] y_addr,
    output logic              mem_rd,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [ADDR_W:0]   z_addr,
    output logic              z_wr,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_cnt
);

    localparam logic [ADDR_W:0]   I_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   I_TWO = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] K_ONE = ADDR_W'(1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W:0]     r_n, r_m, r_i;
    logic [ADDR_W-1:0]   r_k;
    logic                r_mac_en;
    logic [ADDR_W-1:0]   w_k_lo, w_k_hi;
    logic                w_last;

    conv_index_bounds #(.ADDR_W(ADDR_W)) u_bounds (
        .i_idx    (r_i),
        .i_size_x (r_n),
        .i_size_y (r_m),
        .o_k_lo   (w_k_lo),
        .o_k_hi   (w_k_hi)
    );

    assign w_last = (r_i == r_n + r_m - I_TWO);

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a)    r_state <= IDLE;
        else if (en_s) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_rd      = 1'b0;
        mac_clr     = 1'b0;
        z_wr        = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = (size_x == '0 || size_y == '0) ? DONE : INIT;
            end
            INIT: begin
                mac_clr     = 1'b1;
                w_state_nxt = FETCH;
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (r_k == w_k_hi) w_state_nxt = DRAIN;
            end
            DRAIN: w_state_nxt = WRITE;
            WRITE: begin
                z_wr        = 1'b1;
                w_state_nxt = w_last ? DONE : INIT;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_n      <= '0;
            r_m      <= '0;
            r_i      <= '0;
            r_k      <= '0;
            r_mac_en <= 1'b0;
        end else if (en_s) begin
            // mac_en trails mem_rd by the memory read latency
            r_mac_en <= mem_rd;
            case (r_state)
                IDLE:  if (start) begin
                    r_n <= size_x;
                    r_m <= size_y;
                    r_i <= '0;
                end
                INIT:  r_k <= w_k_lo;
                FETCH: if (r_k != w_k_hi) r_k <= r_k + K_ONE;
                WRITE: if (!w_last) r_i <= r_i + I_ONE;
                default: ;
            endcase
        end
    end

    assign mac_en = r_mac_en;
    assign x_addr = r_k;
    // i-k < M <= 2**ADDR_W, so the low bits alone give the exact address
    assign y_addr = r_i[ADDR_W-1:0] - r_k;
    assign z_addr = r_i;

`ifdef CONV_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_cycle_cnt <= '0;
        end else if (en_s) begin
            if (r_state == IDLE && start)
                r_cycle_cnt <= '0;
            else if (busy && r_cycle_cnt != 32'hFFFF_FFFF)
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: table of sizes plus start/reset/freeze corner sequences.
module tb_conv_sequencer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        en_s = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  size_x = '0, size_y = '0;
    logic [4:0]  x_addr, y_addr;
    logic        mem_rd, mac_clr, mac_en, z_wr, busy, done;
    logic [5:0]  z_addr;
    logic [31:0] cycle_cnt;

    conv_sequencer #(.ADDR_W(5)) dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start),
        .size_x(size_x), .size_y(size_y),
        .x_addr(x_addr), .y_addr(y_addr), .mem_rd(mem_rd),
        .mac_clr(mac_clr), .mac_en(mac_en), .z_addr(z_addr),
        .z_wr(z_wr), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0, n_pass = 0;
    int n_busy, n_rd, n_zwr, n_done, n_macbad, done_cyc, first_z, last_z, max_x;
    int last_fx, last_fy, s_cyc;
    int fx_q[$], fy_q[$];
    int Z[64];
    int xd, yd, acc;
    logic prev_rd;

    function automatic int xv(int k); return (k * 3 + 1) % 16; endfunction
    function automatic int yv(int k); return (k * 5 + 2) % 16; endfunction

    function automatic int zref(int i, int n, int m);
        int s = 0;
        for (int k = 0; k < n; k++)
            if (i - k >= 0 && i - k < m) s += xv(k) * yv(i - k);
        return s;
    endfunction

    function automatic logic [53:0] outs();
        return {x_addr, y_addr, mem_rd, mac_clr, mac_en, z_addr, z_wr, busy, done, cycle_cnt};
    endfunction

    // Memory (1-cycle read latency), MAC and Z memory reference model plus event counters
    always @(negedge clk) begin
        if (!rst_a) begin
            prev_rd = 1'b0;
        end else if (en_s) begin
            if (busy) n_busy++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (mac_en != prev_rd) n_macbad++;
            if (mac_en && (mac_clr || z_wr)) n_macbad++;
            prev_rd = mem_rd;
            if (z_wr) begin
                Z[z_addr] = acc;
                n_zwr++;
                if (first_z < 0) first_z = int'(z_addr);
                last_z = int'(z_addr);
            end
            if (mac_clr) acc = 0;
            else if (mac_en) acc += xd * yd;
            if (mem_rd) begin
                xd = xv(int'(x_addr));
                yd = yv(int'(y_addr));
                n_rd++;
                fx_q.push_back(int'(x_addr));
                fy_q.push_back(int'(y_addr));
                last_fx = int'(x_addr);
                last_fy = int'(y_addr);
                if (int'(x_addr) > max_x) max_x = int'(x_addr);
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_busy = 0; n_rd = 0; n_zwr = 0; n_done = 0; n_macbad = 0;
        done_cyc = -1; first_z = -1; last_z = -1; max_x = -1;
        last_fx = -1; last_fy = -1;
        fx_q.delete(); fy_q.delete();
        for (int i = 0; i < 64; i++) Z[i] = -1;
    endtask

    task automatic kick(int sx, int sy);
        size_x = 6'(sx);
        size_y = 6'(sy);
        start  = 1'b1;
        s_cyc  = cyc;
        step(1);
        start  = 1'b0;
    endtask

    task automatic wait_done(string nm);
        for (int t = 0; t < 2000 && n_done == 0; t++) step(1);
        chk({nm, "_done_seen"}, n_done, 1);
    endtask

    task automatic zcheck(string nm, int n, int m);
        int errs = 0;
        int nz = (n == 0 || m == 0) ? 0 : n + m - 1;
        for (int i = 0; i < 64; i++)
            if (Z[i] != ((i < nz) ? zref(i, n, m) : -1)) errs++;
        chk({nm, "_zdata_errs"}, errs, 0);
    endtask

    function automatic int exp_cc(int b);
`ifdef CONV_CYCLE_CNT_EN
        return b;
`else
        return b * 0;
`endif
    endfunction

    typedef struct {
        int sx, sy;
        int zwr, rd, busy_cyc, last_z;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int hit, bad;
        logic [53:0] snap;
        int efx[6], efy[6];

        vecs[0] = '{3, 2, 4, 6, 19, 3};
        vecs[1] = '{0, 5, 0, 0, 1, -1};
        vecs[2] = '{5, 0, 0, 0, 1, -1};
        vecs[3] = '{1, 1, 1, 1, 5, 0};
        vecs[4] = '{2, 3, 4, 6, 19, 3};
        vecs[5] = '{4, 1, 4, 4, 17, 3};
        vecs[6] = '{1, 32, 32, 32, 129, 31};
        vecs[7] = '{32, 32, 63, 1024, 1214, 62};
        efx = '{0, 0, 1, 1, 2, 2};
        efy = '{0, 1, 0, 1, 0, 1};
        xd = 0; yd = 0; acc = 0; prev_rd = 1'b0;
        clear_mon();

        #12;
        chk("reset_outputs_nonzero", int'(outs() != '0), 0);
        step(1);
        rst_a = 1'b1;
        step(2);

        foreach (vecs[r]) begin
            string nm = $sformatf("N%0d_M%0d", vecs[r].sx, vecs[r].sy);
            clear_mon();
            kick(vecs[r].sx, vecs[r].sy);
            wait_done(nm);
            step(3);
            chk({nm, "_zwr"}, n_zwr, vecs[r].zwr);
            chk({nm, "_mem_rd"}, n_rd, vecs[r].rd);
            chk({nm, "_busy_cycles"}, n_busy, vecs[r].busy_cyc);
            chk({nm, "_done_latency"}, done_cyc - s_cyc, vecs[r].busy_cyc);
            chk({nm, "_first_z"}, first_z, (vecs[r].zwr > 0) ? 0 : -1);
            chk({nm, "_last_z"}, last_z, vecs[r].last_z);
            chk({nm, "_mac_en_bad"}, n_macbad, 0);
            chk({nm, "_cycle_cnt"}, int'(cycle_cnt), exp_cc(vecs[r].busy_cyc));
            chk({nm, "_busy_after"}, int'(busy), 0);
            zcheck(nm, vecs[r].sx, vecs[r].sy);
            if (vecs[r].sx == 32 && vecs[r].sy == 32) begin
                chk("N32_last_fetch_x", last_fx, 31);
                chk("N32_last_fetch_y", last_fy, 31);
                chk("N32_max_x", max_x, 31);
            end
        end

        // Extra start pulses mid-run and during the DONE cycle are ignored
        clear_mon();
        kick(3, 2);
        step(3);
        size_x = 6'd1; size_y = 6'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(14);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("dstart_zwr", n_zwr, 4);
        chk("dstart_busy_cycles", n_busy, 19);
        chk("dstart_done_cnt", n_done, 1);
        chk("dstart_done_latency", done_cyc - s_cyc, 19);
        chk("dstart_busy_after", int'(busy), 0);
        chk("dstart_fetch_cnt", fx_q.size(), 6);
        bad = 0;
        for (int j = 0; j < 6 && j < fx_q.size(); j++)
            if (fx_q[j] != efx[j] || fy_q[j] != efy[j]) bad++;
        chk("dstart_fetch_order_errs", bad, 0);
        zcheck("dstart", 3, 2);

        // Asynchronous reset during FETCH of i=2
        clear_mon();
        kick(3, 2);
        hit = 0;
        for (int t = 0; t < 50 && hit == 0; t++) begin
            if (mem_rd && z_addr == 6'd2) hit = 1;
            else step(1);
        end
        chk("abort_reached_i2_fetch", hit, 1);
        #2;
        rst_a = 1'b0;
        #1;
        chk("abort_outputs_nonzero", int'(outs() != '0), 0);
        chk("abort_zwr_before", n_zwr, 2);
        step(2);
        rst_a = 1'b1;
        step(3);
        chk("abort_no_done", n_done, 0);
        chk("abort_zwr_after", n_zwr, 2);
        clear_mon();
        kick(3, 2);
        wait_done("restart");
        step(2);
        chk("restart_first_z", first_z, 0);
        chk("restart_zwr", n_zwr, 4);
        zcheck("restart", 3, 2);

        // en_s low for 5 cycles in the middle of a FETCH burst
        clear_mon();
        kick(3, 2);
        hit = 0;
        for (int t = 0; t < 50 && hit == 0; t++) begin
            if (mem_rd && z_addr == 6'd1) hit = 1;
            else step(1);
        end
        chk("freeze_reached_fetch", hit, 1);
        en_s = 1'b0;
        #1;
        snap = outs();
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            step(1);
            if (outs() != snap) bad++;
        end
        en_s = 1'b1;
        chk("freeze_outputs_moved", bad, 0);
        wait_done("freeze");
        step(2);
        chk("freeze_busy_cycles", n_busy, 19);
        chk("freeze_zwr", n_zwr, 4);
        chk("freeze_mac_en_bad", n_macbad, 0);
        chk("freeze_cycle_cnt", int'(cycle_cnt), exp_cc(19));
        zcheck("freeze", 3, 2);
        step(3);
        chk("freeze_cycle_cnt_hold", int'(cycle_cnt), exp_cc(19));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
